// File: rtl/bin2bcd_pkg.sv
// Shared types and elaboration-time helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // 10^n as a 64-bit constant. 10^10 is the largest value needed and fits easily.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // Width of a counter that must hold the value bin_w.
  function automatic int cnt_w(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

  // Fewest decimal digits that can represent every bin_w-bit unsigned value.
  function automatic int min_digits(input int bin_w);
    logic [63:0] top;
    int d;
    top = (64'd1 << bin_w) - 64'd1;
    d = 1;
    while (pow10(d) - 64'd1 < top) begin
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_digit_adj.sv
// One BCD digit correction for double dabble: add 3 when the digit is 5 or more.
// Inputs are always legal BCD (0..9), so the result never exceeds 4'hC.
module bin2bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Add-3-if-at-least-5 correction, 4-bit wrap.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble shift per clock.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// in_ready is 1 only in IDLE; out_valid is 1 only in DONE. Once out_valid is high,
// out_bcd/out_neg/out_ovf stay constant until the edge where out_ready is seen high.
// Both ready/valid outputs are decoded from the state register, so there is no
// combinational path from any input to any output.
import bin2bcd_pkg::*;

module bin2bcd_seq #(
  parameter int BIN_W     = 16,
  parameter int DIGITS    = 5,
  parameter int SIGNED_IN = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  out_ovf,
  output state_t                dbg_state
);

  localparam int          CW    = cnt_w(BIN_W);
  localparam int          BW    = 4 * DIGITS;
  localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;
  localparam logic [BW-1:0] NINES = {DIGITS{4'h9}};

  // Parameter range checks. A DIGITS value below min_digits(BIN_W) is legal:
  // large inputs simply saturate through the overflow path.
  if (BIN_W < 2 || BIN_W > 32) begin : g_bad_bin_w
    $error("bin2bcd_seq: BIN_W=%0d outside 2..32", BIN_W);
  end
  if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS=%0d outside 1..10", DIGITS);
  end

  state_t          state, state_nxt;
  logic [BW-1:0]   acc, acc_nxt;
  logic [BW-1:0]   acc_adj;
  logic [BW-1:0]   acc_shift;
  logic [BIN_W-1:0] mag, mag_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            neg, neg_nxt;
  logic            ovf, ovf_nxt;
  logic [BW-1:0]   bcd_nxt;
  logic            oneg_nxt;
  logic            oovf_nxt;

  logic            in_neg;
  logic [BIN_W-1:0] in_mag;
  logic            in_ovf;

  // Per-digit add-3 correction applied before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bin2bcd_digit_adj u_adj (
      .din  (acc[4*g +: 4]),
      .dout (acc_adj[4*g +: 4])
    );
  end

  // Magnitude, sign and overflow of the incoming word; the most negative value
  // negates to itself, which read unsigned is 2^(BIN_W-1) as required.
  always_comb begin
    in_neg = (SIGNED_IN != 0) && in_bin[BIN_W-1];
    in_mag = in_neg ? -in_bin : in_bin;
    in_ovf = 64'(in_mag) > LIMIT;
  end

  // Corrected accumulator shifted left by one with the mag MSB entering digit 0;
  // the bit pushed out of the top digit is dropped by the truncating cast.
  always_comb begin
    acc_shift = BW'({acc_adj, mag[BIN_W-1]});
  end

  // Next-state and datapath control.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    mag_nxt   = mag;
    cnt_nxt   = cnt;
    neg_nxt   = neg;
    ovf_nxt   = ovf;
    bcd_nxt   = out_bcd;
    oneg_nxt  = out_neg;
    oovf_nxt  = out_ovf;
    case (state)
      IDLE: begin
        if (in_valid) begin
          mag_nxt   = in_mag;
          neg_nxt   = in_neg;
          ovf_nxt   = in_ovf;
          acc_nxt   = '0;
          cnt_nxt   = CW'(BIN_W);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        acc_nxt = acc_shift;
        mag_nxt = mag << 1;
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          // Final shift: latch the result, saturating when out of range.
          state_nxt = DONE;
          bcd_nxt   = ovf ? NINES : acc_shift;
          oneg_nxt  = neg;
          oovf_nxt  = ovf;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mag     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
      out_bcd <= '0;
      out_neg <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      mag     <= mag_nxt;
      cnt     <= cnt_nxt;
      neg     <= neg_nxt;
      ovf     <= ovf_nxt;
      out_bcd <= bcd_nxt;
      out_neg <= oneg_nxt;
      out_ovf <= oovf_nxt;
    end
  end

  // Handshake flags and debug view decoded from the state register.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    dbg_state = state;
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq across four parameter sets.
// Instance index: 0 = (16,5,unsigned), 1 = (16,4,unsigned), 2 = (16,5,signed), 3 = (4,1,unsigned).
import bin2bcd_pkg::*;

module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic [3:0]  iv;
  logic [3:0]  ordy;
  logic [15:0] bin16;

  logic [3:0]  irdy;
  logic [3:0]  ov;
  logic [3:0]  negv;
  logic [3:0]  ovfv;
  logic [19:0] bcd_a;
  logic [15:0] bcd_b;
  logic [19:0] bcd_c;
  logic [3:0]  bcd_d;
  state_t      st_a, st_b, st_c, st_d;

  int checks   = 0;
  int failures = 0;
  int wid [4]  = '{16, 16, 16, 4};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED_IN(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .in_bin(bin16),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_bcd(bcd_a), .out_neg(negv[0]),
    .out_ovf(ovfv[0]), .dbg_state(st_a));

  bin2bcd_seq #(.BIN_W(16), .DIGITS(4), .SIGNED_IN(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .in_bin(bin16),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_bcd(bcd_b), .out_neg(negv[1]),
    .out_ovf(ovfv[1]), .dbg_state(st_b));

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED_IN(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .in_bin(bin16),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_bcd(bcd_c), .out_neg(negv[2]),
    .out_ovf(ovfv[2]), .dbg_state(st_c));

  bin2bcd_seq #(.BIN_W(4), .DIGITS(1), .SIGNED_IN(0)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(irdy[3]), .in_bin(bin16[3:0]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_bcd(bcd_d), .out_neg(negv[3]),
    .out_ovf(ovfv[3]), .dbg_state(st_d));

  function automatic logic [19:0] get_bcd(input int k);
    case (k)
      0:       return bcd_a;
      1:       return {4'h0, bcd_b};
      2:       return bcd_c;
      default: return {16'h0, bcd_d};
    endcase
  endfunction

  function automatic state_t get_state(input int k);
    case (k)
      0:       return st_a;
      1:       return st_b;
      2:       return st_c;
      default: return st_d;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Waits (bounded) for out_valid of instance k; called at the negedge after the
  // accept edge, so the returned count equals the edges from accept to valid.
  task automatic wait_valid(input int k, input string tag);
    int n;
    n = 0;
    while (ov[k] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":latency"}, 32'(n), 32'(wid[k]));
  endtask

  task automatic convert(input int k, input logic [15:0] v, input logic [19:0] eb,
                         input logic en, input logic eo, input string tag);
    @(negedge clk);
    check({tag, ":in_ready_idle"}, 32'(irdy[k]), 32'd1);
    ordy[k] = 1'b1;
    iv[k]   = 1'b1;
    bin16   = v;
    @(negedge clk);
    iv[k] = 1'b0;
    bin16 = ~v;
    check({tag, ":state_shift"}, 32'(get_state(k)), 32'(SHIFT));
    wait_valid(k, tag);
    check({tag, ":bcd"}, 32'(get_bcd(k)), 32'(eb));
    check({tag, ":neg"}, 32'(negv[k]), 32'(en));
    check({tag, ":ovf"}, 32'(ovfv[k]), 32'(eo));
    @(negedge clk);
    check({tag, ":in_ready_after"}, 32'(irdy[k]), 32'd1);
    check({tag, ":valid_after"}, 32'(ov[k]), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    iv    = '0;
    ordy  = '0;
    bin16 = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst%0d:in_ready", k), 32'(irdy[k]), 32'd1);
      check($sformatf("rst%0d:out_valid", k), 32'(ov[k]), 32'd0);
      check($sformatf("rst%0d:bcd", k), 32'(get_bcd(k)), 32'd0);
      check($sformatf("rst%0d:neg", k), 32'(negv[k]), 32'd0);
      check($sformatf("rst%0d:ovf", k), 32'(ovfv[k]), 32'd0);
    end
    rst_n = 1'b1;

    // Unsigned, enough digits.
    convert(0, 16'd65535, 20'h65535, 1'b0, 1'b0, "a_65535");
    convert(0, 16'd12345, 20'h12345, 1'b0, 1'b0, "a_12345");
    convert(0, 16'd0,     20'h00000, 1'b0, 1'b0, "a_zero");
    convert(0, 16'd40960, 20'h40960, 1'b0, 1'b0, "a_40960");

    // One digit short: saturation around the 9999 boundary.
    convert(1, 16'd12345, 20'h09999, 1'b0, 1'b1, "b_12345");
    convert(1, 16'd9999,  20'h09999, 1'b0, 1'b0, "b_9999");
    convert(1, 16'd1000,  20'h01000, 1'b0, 1'b0, "b_1000");
    convert(1, 16'd10000, 20'h09999, 1'b0, 1'b1, "b_10000");

    // Two's complement input.
    convert(2, 16'h0000, 20'h00000, 1'b0, 1'b0, "c_zero");
    convert(2, 16'h7FFF, 20'h32767, 1'b0, 1'b0, "c_7fff");
    convert(2, 16'h8000, 20'h32768, 1'b1, 1'b0, "c_8000");
    convert(2, 16'hFFFF, 20'h00001, 1'b1, 1'b0, "c_ffff");

    // Narrow width, single digit.
    convert(3, 16'd5,  20'h5, 1'b0, 1'b0, "d_5");
    convert(3, 16'd9,  20'h9, 1'b0, 1'b0, "d_9");
    convert(3, 16'd10, 20'h9, 1'b0, 1'b1, "d_10");
    convert(3, 16'd15, 20'h9, 1'b0, 1'b1, "d_15");

    // Backpressure: result held, no accept while DONE, inputs toggling.
    @(negedge clk);
    ordy[0] = 1'b0;
    iv[0]   = 1'b1;
    bin16   = 16'd12345;
    @(negedge clk);
    iv[0] = 1'b0;
    wait_valid(0, "bp");
    for (int i = 0; i < 10; i++) begin
      iv[0] = 1'b1;
      bin16 = i[0] ? 16'hAAAA : 16'h5555;
      @(negedge clk);
      check($sformatf("bp%0d:bcd", i), 32'(bcd_a), 32'h12345);
      check($sformatf("bp%0d:valid", i), 32'(ov[0]), 32'd1);
      check($sformatf("bp%0d:in_ready", i), 32'(irdy[0]), 32'd0);
      check($sformatf("bp%0d:ovf", i), 32'(ovfv[0]), 32'd0);
    end
    bin16   = 16'd4321;
    ordy[0] = 1'b1;
    @(negedge clk);
    check("bp_rel:in_ready", 32'(irdy[0]), 32'd1);
    check("bp_rel:valid", 32'(ov[0]), 32'd0);
    @(negedge clk);
    iv[0] = 1'b0;
    check("bp_next:in_ready", 32'(irdy[0]), 32'd0);
    check("bp_next:state", 32'(st_a), 32'(SHIFT));
    wait_valid(0, "bp_next");
    check("bp_next:bcd", 32'(bcd_a), 32'h04321);
    @(negedge clk);

    // Asynchronous reset in SHIFT cycle 7 of instance 0; the other instances hold
    // nonzero results (b ovf=1, c neg=1, d bcd=9) which must also clear.
    iv[0] = 1'b1;
    bin16 = 16'd65535;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst:state", 32'(st_a), 32'(IDLE));
    check("arst:in_ready", 32'(irdy[0]), 32'd1);
    check("arst:valid", 32'(ov[0]), 32'd0);
    check("arst:bcd_a", 32'(bcd_a), 32'd0);
    check("arst:ovf_b", 32'(ovfv[1]), 32'd0);
    check("arst:bcd_b", 32'(bcd_b), 32'd0);
    check("arst:neg_c", 32'(negv[2]), 32'd0);
    check("arst:bcd_d", 32'(bcd_d), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    convert(0, 16'd0, 20'h00000, 1'b0, 1'b0, "post_rst_zero");
    convert(2, 16'hFFF6, 20'h00010, 1'b1, 1'b0, "post_rst_neg10");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
